// File: rtl/encoder_step_sequencer_pkg.sv
// Shared definitions for the encoder step sequencer.
//   seq_state_e      : sequencer FSM states
//   DIR_HORARIO      : command direction value for clockwise steps
//   DIR_ANTIHORARIO  : command direction value for counter-clockwise steps
//   *_W_DEF          : default widths for step count, period and position
package encoder_seq_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 16;
  localparam int POS_W_DEF = 16;

  localparam logic DIR_HORARIO     = 1'b1;
  localparam logic DIR_ANTIHORARIO = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/encoder_step_sequencer_if.sv
// Move-command handshake between a command source and the step sequencer.
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : sequencer can accept a command (slave -> master)
//   cmd_dir    : 1 = horario, 0 = antihorario
//   cmd_steps  : number of steps to emit
//   cmd_period : idle cycles between consecutive pulses
interface encoder_step_sequencer_if
  import encoder_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/encoder_step_sequencer_step_timer.sv
// Inter-step down-counter for the step sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val into the counter (wins over en)
//   en         : decrement by one while non-zero
//   load_val   : value to load
//   expire     : counter currently at terminal count (1)
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] timer_q;
  logic [DIV_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = load_val;
    end else if (en && (timer_q != '0)) begin
      timer_d = timer_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Terminal count is 1, not 0, so a load of P yields exactly P wait cycles.
  assign expire = (timer_q == DIV_W'(1));

endmodule

// File: rtl/encoder_step_sequencer.sv
// Command-driven step scheduler feeding the quadrature Encoder block.
//   clk, rst_n  : clock, synchronous active-low reset
//   cmd         : move-command handshake (slave side)
//   abort       : stop the current move
//   horario     : one-cycle clockwise step pulse
//   antihorario : one-cycle counter-clockwise step pulse
//   busy        : move in progress
//   done        : one-cycle completion pulse
//   steps_done  : pulses emitted in the current/last move
//   position    : signed net step count (wraps, cleared only by reset)
//
// state | meaning
// IDLE  | ready for a command
// STEP  | emitting one pulse this cycle
// WAIT  | idle gap between pulses, timed by step_timer
// DONE  | one-cycle completion pulse
module encoder_step_sequencer
  import encoder_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  encoder_step_sequencer_if.slave cmd,
  input  logic                    abort,
  output logic                    horario,
  output logic                    antihorario,
  output logic                    busy,
  output logic                    done,
  output logic        [CNT_W-1:0] steps_done,
  output logic signed [POS_W-1:0] position
);

  seq_state_e state_q, state_d;

  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] steps_done_q, steps_done_d;
  logic [POS_W-1:0] position_q, position_d;

  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] steps_done_inc;
  logic             timer_load;
  logic             timer_en;
  logic             timer_expire;

  assign accept         = (state_q == IDLE) && cmd.cmd_valid;
  assign steps_done_inc = steps_done_q + CNT_W'(1);
  assign last_step      = (steps_done_inc == steps_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = (cmd.cmd_steps == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        // Abort here still lets the current pulse out; it is already visible.
        if (last_step || abort) begin
          state_d = DONE;
        end else if (period_q == '0) begin
          state_d = STEP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = DONE;
        end else if (timer_expire) begin
          state_d = STEP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cmd.cmd_ready = (state_q == IDLE);
    busy          = (state_q == STEP) || (state_q == WAIT);
    done          = (state_q == DONE);
    horario       = (state_q == STEP) && (dir_q == DIR_HORARIO);
    antihorario   = (state_q == STEP) && (dir_q == DIR_ANTIHORARIO);
  end

  // Command latch, step counter and position accumulator
  always_comb begin
    dir_d        = dir_q;
    steps_d      = steps_q;
    period_d     = period_q;
    steps_done_d = steps_done_q;
    position_d   = position_q;
    if (accept) begin
      dir_d        = cmd.cmd_dir;
      steps_d      = cmd.cmd_steps;
      period_d     = cmd.cmd_period;
      steps_done_d = '0;
    end
    if (state_q == STEP) begin
      steps_done_d = steps_done_inc;
      position_d   = (dir_q == DIR_HORARIO) ? position_q + POS_W'(1)
                                            : position_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q        <= 1'b0;
      steps_q      <= '0;
      period_q     <= '0;
      steps_done_q <= '0;
      position_q   <= '0;
    end else begin
      dir_q        <= dir_d;
      steps_q      <= steps_d;
      period_q     <= period_d;
      steps_done_q <= steps_done_d;
      position_q   <= position_d;
    end
  end

  // Timer is loaded only when leaving STEP for a non-zero gap.
  assign timer_load = (state_q == STEP) && (state_d == WAIT);
  assign timer_en   = (state_q == WAIT);

  step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (period_q),
    .expire   (timer_expire)
  );

  assign steps_done = steps_done_q;
  assign position   = position_q;

endmodule

// File: tb/tb_encoder_step_sequencer.sv
module tb_encoder_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        horario;
  logic        antihorario;
  logic        busy;
  logic        done;
  logic [15:0] steps_done;
  logic [15:0] position;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_pos = 16'd0;

  encoder_step_sequencer_if #(.CNT_W(16), .DIV_W(16)) cmd_if ();

  encoder_step_sequencer #(
    .CNT_W (16),
    .DIV_W (16),
    .POS_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .abort       (abort),
    .horario     (horario),
    .antihorario (antihorario),
    .busy        (busy),
    .done        (done),
    .steps_done  (steps_done),
    .position    (position)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses emitted strictly before cycle t; slots are t' = 1 + i*(p+1), t' < done_t.
  function automatic int pulses_before(input int t, input int p, input int done_t);
    int m;
    m = (t - 1 < done_t - 1) ? t - 1 : done_t - 1;
    return (m >= 1) ? ((m - 1) / (p + 1) + 1) : 0;
  endfunction

  // Offer one command and check every output cycle by cycle until one cycle after done.
  // abort_at: cycle (relative to acceptance) during which abort is held; 0 = none.
  task automatic run_move(input bit dir, input int n, input int p, input int abort_at,
                          input bit hold_valid);
    int          done_t;
    int          np;
    bit          pulse;
    logic [15:0] pos0;
    logic [15:0] exp_pos;
    pos0   = model_pos;
    done_t = (n == 0) ? 1 : 1 + (n - 1) * (p + 1) + 1;
    if (abort_at >= 1 && abort_at < done_t) done_t = abort_at + 1;
    @(negedge clk);
    chk("ready_before_cmd", {31'd0, cmd_if.cmd_ready}, 32'd1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_steps  = n[15:0];
    cmd_if.cmd_period = p[15:0];
    exp_pos = pos0;
    for (int t = 1; t <= done_t + 1; t++) begin
      @(negedge clk);
      pulse   = (t < done_t) && (((t - 1) % (p + 1)) == 0);
      np      = pulses_before(t, p, done_t);
      exp_pos = dir ? pos0 + np[15:0] : pos0 - np[15:0];
      chk("horario",     {31'd0, horario},          {31'd0, pulse && dir});
      chk("antihorario", {31'd0, antihorario},      {31'd0, pulse && !dir});
      chk("busy",        {31'd0, busy},             {31'd0, t < done_t});
      chk("done",        {31'd0, done},             {31'd0, t == done_t});
      chk("cmd_ready",   {31'd0, cmd_if.cmd_ready}, {31'd0, t > done_t});
      chk("steps_done",  {16'd0, steps_done},       np);
      chk("position",    {16'd0, position},         {16'd0, exp_pos});
      if (!hold_valid || t >= done_t) begin
        cmd_if.cmd_valid = 1'b0;
      end else begin
        cmd_if.cmd_dir    = 1'($urandom_range(0, 1));
        cmd_if.cmd_steps  = 16'($urandom_range(0, 20));
        cmd_if.cmd_period = 16'($urandom_range(0, 5));
      end
      abort = (t == abort_at);
    end
    abort     = 1'b0;
    model_pos = exp_pos;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_pos = 16'd0;
  endtask

  initial begin
    int n, p, a;
    bit d, h;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_steps  = 16'd0;
    cmd_if.cmd_period = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",       {31'd0, busy},             32'd0);
    chk("rst_done",       {31'd0, done},             32'd0);
    chk("rst_ready",      {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_position",   {16'd0, position},         32'd0);
    chk("rst_steps_done", {16'd0, steps_done},       32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a move: accepted, pulse at t=1, WAIT at t=2,3.
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = 1'b1;
    cmd_if.cmd_steps  = 16'd10;
    cmd_if.cmd_period = 16'd5;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("mid_first_pulse", {31'd0, horario}, 32'd1);
    repeat (2) @(negedge clk);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_horario",  {31'd0, horario},          32'd0);
    chk("mid_rst_busy",     {31'd0, busy},             32'd0);
    chk("mid_rst_done",     {31'd0, done},             32'd0);
    chk("mid_rst_ready",    {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("mid_rst_position", {16'd0, position},         32'd0);
    chk("mid_rst_steps",    {16'd0, steps_done},       32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done",  {31'd0, done},    32'd0);
      chk("mid_rst_no_pulse", {31'd0, horario}, 32'd0);
    end
    model_pos = 16'd0;

    // Directed moves from the test plan.
    run_move(1'b1, 3, 2, 0, 1'b0);
    chk("plan1_position", {16'd0, position}, 32'd3);
    chk("plan1_steps",    {16'd0, steps_done}, 32'd3);
    run_move(1'b0, 4, 0, 0, 1'b0);
    chk("plan2_position", {16'd0, position}, 32'h0000_FFFF);
    run_move(1'b0, 0, 3, 0, 1'b0);
    chk("zero_steps_position", {16'd0, position}, 32'h0000_FFFF);
    run_move(1'b1, 10, 3, 6, 1'b0);
    chk("abort_wait_steps", {16'd0, steps_done}, 32'd2);
    run_move(1'b0, 10, 3, 5, 1'b0);
    chk("abort_step_steps", {16'd0, steps_done}, 32'd2);
    run_move(1'b1, 5, 1, 0, 1'b1);
    run_move(1'b0, 3, 0, 2, 1'b1);

    // Randomized moves against the model.
    for (int k = 0; k < 24; k++) begin
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 12);
      p = $urandom_range(0, 4);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      h = ($urandom_range(0, 3) == 0);
      run_move(d, n, p, a, h);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Position wrap: climb to +32767 then one more clockwise step.
    do_reset();
    run_move(1'b1, 32767, 0, 0, 1'b0);
    chk("wrap_max", {16'd0, position}, 32'h0000_7FFF);
    run_move(1'b1, 1, 0, 0, 1'b0);
    chk("wrap_min", {16'd0, position}, 32'h0000_8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
